// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared constants and FSM state type for the conv instruction path
//
// Purpose: instruction width, RAM address width, instruction field positions
// and the fetch FSM state encoding. Instructions pass through the fetch stage
// bit-exact; the field positions are informational for downstream stages.
package conv_pkg;

  localparam int IW  = 40;
  localparam int IAW = 8;

  // Instruction fields consumed by conv_inst_loop.
  localparam int INST_ADDR_LSB = 8;
  localparam int INST_ADDR_MSB = 21;
  localparam int INST_LOOP_LSB = 22;
  localparam int INST_LOOP_MSB = 28;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/conv_inst_fifo.sv
// rtl/conv_inst_fifo.sv - 2-entry synchronous FIFO for fetched instructions
//
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   i_push       : write i_push_data at the tail (ignored when full without pop)
//   i_push_data  : instruction to store
//   i_pop        : drop the head entry (ignored when empty)
//   o_head       : current head entry
//   o_cnt        : number of stored entries (0..2)
module conv_inst_fifo import conv_pkg::*; #(
  parameter int W = IW
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_push_data,
  input  logic         i_pop,
  output logic [W-1:0] o_head,
  output logic [1:0]   o_cnt
);

  logic [W-1:0] r_mem [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_cnt;
  logic         w_push;
  logic         w_pop;

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign w_pop  = i_pop && (r_cnt != 2'd0);
  assign w_push = i_push && ((r_cnt != 2'd2) || w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  assign o_head = r_mem[r_rd_ptr];
  assign o_cnt  = r_cnt;

endmodule

// File: rtl/conv_inst_fetch.sv
// rtl/conv_inst_fetch.sv - instruction fetch stage feeding conv_inst_loop
//
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   start               : one-cycle request, sampled only in IDLE
//   base_addr, inst_num : first RAM address and instruction count (0 legal)
//   busy, done          : busy from cycle after start through done; done on last transfer
//   mem_en, mem_addr    : synchronous RAM read port, 1-cycle read latency
//   mem_rdata           : RAM read data
//   s_inst, s_valid     : instruction stream out
//   s_ready             : downstream accept
module conv_inst_fetch import conv_pkg::*; #(
  parameter int IW  = conv_pkg::IW,
  parameter int IAW = conv_pkg::IAW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [IAW-1:0] base_addr,
  input  logic [IAW-1:0] inst_num,
  output logic           busy,
  output logic           done,
  output logic           mem_en,
  output logic [IAW-1:0] mem_addr,
  input  logic [IW-1:0]  mem_rdata,
  output logic [IW-1:0]  s_inst,
  output logic           s_valid,
  input  logic           s_ready
);

  localparam logic [IAW-1:0] ONE = IAW'(1);

  fetch_state_e   r_state;
  logic [IAW-1:0] r_base;
  logic [IAW-1:0] r_num;
  logic [IAW-1:0] r_issued;
  logic [IAW-1:0] r_accepted;
  logic           r_inflight;

  logic [1:0]     w_fifo_cnt;
  logic [IW-1:0]  w_fifo_head;
  logic           w_xfer;
  logic           w_credit;
  logic           w_last_xfer;

  conv_inst_fifo #(.W(IW)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (r_inflight),
    .i_push_data (mem_rdata),
    .i_pop       (w_xfer),
    .o_head      (w_fifo_head),
    .o_cnt       (w_fifo_cnt)
  );

  assign s_valid = (w_fifo_cnt != 2'd0);
  assign s_inst  = w_fifo_head;
  assign w_xfer  = s_valid && s_ready;

  // Entries held plus the beat still in the RAM pipe must leave room, counting
  // a pop happening this very cycle so issue resumes without a bubble.
  assign w_credit = ({1'b0, w_fifo_cnt} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_xfer});

  assign mem_en   = (r_state == ST_FETCH) && (r_issued != r_num) && w_credit;
  assign mem_addr = r_base + r_issued;

  // Widened so inst_num = 0 completes on the first DRAIN cycle without a transfer.
  assign w_last_xfer = ({1'b0, r_accepted} + {{IAW{1'b0}}, w_xfer}) == {1'b0, r_num};
  assign done        = (r_state == ST_DRAIN) && w_last_xfer;
  assign busy        = (r_state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_base     <= '0;
      r_num      <= '0;
      r_issued   <= '0;
      r_accepted <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= mem_en;
      if (w_xfer) begin
        r_accepted <= r_accepted + ONE;
      end
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_base     <= base_addr;
            r_num      <= inst_num;
            r_issued   <= '0;
            r_accepted <= '0;
            r_state    <= (inst_num != '0) ? ST_FETCH : ST_DRAIN;
          end
        end
        ST_FETCH: begin
          if (mem_en) begin
            r_issued <= r_issued + ONE;
            if (r_issued == r_num - ONE) begin
              r_state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (done) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_inst_fetch.sv
// tb/tb_conv_inst_fetch.sv - self-checking bench for conv_inst_fetch
module tb_conv_inst_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  base_addr = '0;
  logic [7:0]  inst_num = '0;
  logic        busy, done, mem_en, s_valid;
  logic [7:0]  mem_addr;
  logic [39:0] mem_rdata = '0;
  logic [39:0] s_inst;
  logic        s_ready = 1'b0;

  always #5 clk = ~clk;

  conv_inst_fetch dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .inst_num  (inst_num),
    .busy      (busy),
    .done      (done),
    .mem_en    (mem_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .s_inst    (s_inst),
    .s_valid   (s_valid),
    .s_ready   (s_ready)
  );

  // Instruction RAM model: synchronous read, one cycle latency.
  logic [39:0] ram [256];
  always @(posedge clk) if (mem_en) mem_rdata <= ram[mem_addr];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observation record of one block, rebuilt from pin activity.
  logic [7:0]  addr_q [$];
  logic [39:0] xfer_q [$];
  int first_mem_rel, first_valid_rel, done_rel, done_cnt, valid_cnt;
  int occ, max_occ, hold_viol, stab_viol, busy_after_done;
  logic prev_en, prev_valid, prev_ready, prev_done;
  logic [39:0] prev_inst;

  task automatic clear_mon();
    addr_q.delete();
    xfer_q.delete();
    first_mem_rel = -1; first_valid_rel = -1; done_rel = -1;
    done_cnt = 0; valid_cnt = 0; max_occ = 0; hold_viol = 0; stab_viol = 0;
    busy_after_done = -1;
  endtask

  // Cycle numbering: rel = k means cycle E0+k, where E0 is the edge sampling start.
  always @(negedge clk) begin
    int rel;
    if (rst) begin
      occ = 0; prev_en = 0; prev_valid = 0; prev_ready = 0; prev_done = 0;
    end else begin
      rel = cyc - t0 + 1;
      if (prev_done) busy_after_done = busy ? 1 : 0;
      if (prev_valid && !prev_ready && (!s_valid || s_inst !== prev_inst)) stab_viol++;
      if (s_valid !== (occ > 0)) hold_viol++;
      occ = occ + (prev_en ? 1 : 0) - ((s_valid && s_ready) ? 1 : 0);
      if (occ > max_occ) max_occ = occ;
      if (mem_en) begin
        addr_q.push_back(mem_addr);
        if (first_mem_rel < 0) first_mem_rel = rel;
      end
      if (s_valid) begin
        valid_cnt++;
        if (first_valid_rel < 0) first_valid_rel = rel;
      end
      if (s_valid && s_ready) xfer_q.push_back(s_inst);
      if (done) begin
        done_cnt++;
        done_rel = rel;
      end
      prev_en = mem_en; prev_valid = s_valid; prev_ready = s_ready;
      prev_inst = s_inst; prev_done = done;
    end
  end

  task automatic start_block(input logic [7:0] b, input logic [7:0] n, input bit wait_edge);
    if (wait_edge) begin @(posedge clk); #1; end
    clear_mon();
    base_addr = b; inst_num = n; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    base_addr = 8'($urandom); inst_num = 8'($urandom);
    t0 = cyc;
  endtask

  // mode 0: ready high, 1: toggle, 2: random. spur pulses start while busy.
  task automatic run_until_done(input int mode, input int budget, input bit spur);
    int seen = 0;
    for (int i = 0; i < budget && seen < 3; i++) begin
      @(posedge clk); #1;
      case (mode)
        0: s_ready = 1'b1;
        1: s_ready = ~s_ready;
        default: s_ready = 1'($urandom);
      endcase
      start = 1'b0;
      if (spur && done_cnt == 0 && ($urandom % 3 == 0)) begin
        start = 1'b1; base_addr = 8'($urandom); inst_num = 8'($urandom);
      end
      if (done_cnt > 0) seen++;
    end
    start = 1'b0;
    checks++;
    if (done_cnt == 0) begin
      errors++;
      $display("FAIL timeout: done_cnt=%0d required >0 within %0d cycles", done_cnt, budget);
    end
  endtask

  // Reference: block of n reads from base b, wrapping mod 256, delivered in order.
  task automatic compare_block_seq(input string tag, input logic [7:0] b, input int n);
    logic [7:0] a;
    checks++;
    if (addr_q.size() != n) begin
      errors++; $display("FAIL %s addr_count: got %0d required %0d", tag, addr_q.size(), n);
    end
    checks++;
    if (xfer_q.size() != n) begin
      errors++; $display("FAIL %s xfer_count: got %0d required %0d", tag, xfer_q.size(), n);
    end
    for (int i = 0; i < n; i++) begin
      a = 8'(int'(b) + i);
      if (i < addr_q.size()) begin
        checks++;
        if (addr_q[i] !== a) begin
          errors++; $display("FAIL %s addr[%0d]: got %0h required %0h", tag, i, addr_q[i], a);
        end
      end
      if (i < xfer_q.size()) begin
        checks++;
        if (xfer_q[i] !== ram[a]) begin
          errors++; $display("FAIL %s inst[%0d]: got %0h required %0h", tag, i, xfer_q[i], ram[a]);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; s_ready = 1'b0; start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    checks++; if (done !== 1'b0)    begin errors++; $display("FAIL reset_done: got %b required 0", done); end
    checks++; if (mem_en !== 1'b0)  begin errors++; $display("FAIL reset_mem_en: got %b required 0", mem_en); end
    checks++; if (mem_addr !== 8'h0) begin errors++; $display("FAIL reset_mem_addr: got %0h required 0", mem_addr); end
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL reset_s_valid: got %b required 0", s_valid); end
    checks++; if (s_inst !== 40'h0) begin errors++; $display("FAIL reset_s_inst: got %0h required 0", s_inst); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    s_ready = 1'b1;
    start_block(8'h10, 8'd4, 1'b1);
    run_until_done(0, 50, 1'b0);
    compare_block_seq("basic", 8'h10, 4);
    checks++; if (first_mem_rel != 1)   begin errors++; $display("FAIL basic_first_mem: got E0+%0d required E0+1", first_mem_rel); end
    checks++; if (first_valid_rel != 3) begin errors++; $display("FAIL basic_first_valid: got E0+%0d required E0+3", first_valid_rel); end
    checks++; if (done_rel != 6)        begin errors++; $display("FAIL basic_done_time: got E0+%0d required E0+6", done_rel); end
    checks++; if (done_cnt != 1)        begin errors++; $display("FAIL basic_done_cnt: got %0d required 1", done_cnt); end
    checks++; if (busy_after_done != 0) begin errors++; $display("FAIL basic_busy_fall: got %0d required 0", busy_after_done); end
  endtask

  task automatic test_backpressure();
    s_ready = 1'b0;
    start_block(8'h10, 8'd4, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    checks++; if (addr_q.size() != 2) begin errors++; $display("FAIL bp_reads_held: got %0d required 2", addr_q.size()); end
    checks++; if (s_valid !== 1'b1)   begin errors++; $display("FAIL bp_valid_held: got %b required 1", s_valid); end
    checks++; if (s_inst !== ram[8'h10]) begin errors++; $display("FAIL bp_head: got %0h required %0h", s_inst, ram[8'h10]); end
    checks++; if (stab_viol != 0)     begin errors++; $display("FAIL bp_stable: got %0d violations required 0", stab_viol); end
    run_until_done(0, 50, 1'b0);
    compare_block_seq("bp", 8'h10, 4);
    checks++; if (max_occ > 2) begin errors++; $display("FAIL bp_occupancy: got %0d required <=2", max_occ); end
  endtask

  task automatic test_toggle();
    logic [7:0] b;
    b = 8'($urandom);
    s_ready = 1'b0;
    start_block(b, 8'd6, 1'b1);
    run_until_done(1, 80, 1'b0);
    compare_block_seq("toggle", b, 6);
    checks++; if (max_occ > 2)    begin errors++; $display("FAIL toggle_occupancy: got %0d required <=2", max_occ); end
    checks++; if (hold_viol != 0) begin errors++; $display("FAIL toggle_valid_count: got %0d violations required 0", hold_viol); end
    checks++; if (done_cnt != 1)  begin errors++; $display("FAIL toggle_done_cnt: got %0d required 1", done_cnt); end
  endtask

  task automatic test_wrap();
    start_block(8'hFE, 8'd4, 1'b1);
    run_until_done(2, 100, 1'b0);
    compare_block_seq("wrap", 8'hFE, 4);
  endtask

  task automatic test_zero();
    s_ready = 1'b1;
    start_block(8'h33, 8'd0, 1'b1);
    // Second start lands while the zero-length block is still busy.
    start = 1'b1; base_addr = 8'h50; inst_num = 8'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    checks++; if (addr_q.size() != 0) begin errors++; $display("FAIL zero_mem_en: got %0d reads required 0", addr_q.size()); end
    checks++; if (valid_cnt != 0)     begin errors++; $display("FAIL zero_valid: got %0d cycles required 0", valid_cnt); end
    checks++; if (done_cnt != 1)      begin errors++; $display("FAIL zero_done_cnt: got %0d required 1", done_cnt); end
    checks++; if (done_rel != 1)      begin errors++; $display("FAIL zero_done_time: got E0+%0d required E0+1", done_rel); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL zero_busy_after: got %b required 0", busy); end
  endtask

  task automatic test_reset_mid();
    s_ready = 1'b0;
    start_block(8'h40, 8'd8, 1'b1);
    @(posedge clk); #1;
    // Cycle E0+2: first beat is in the RAM pipe.
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL rmid_busy: got %b required 0", busy); end
    checks++; if (mem_en !== 1'b0)   begin errors++; $display("FAIL rmid_mem_en: got %b required 0", mem_en); end
    checks++; if (mem_addr !== 8'h0) begin errors++; $display("FAIL rmid_mem_addr: got %0h required 0", mem_addr); end
    checks++; if (s_valid !== 1'b0)  begin errors++; $display("FAIL rmid_s_valid: got %b required 0", s_valid); end
    checks++; if (done !== 1'b0)     begin errors++; $display("FAIL rmid_done: got %b required 0", done); end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (s_valid !== 1'b0)  begin errors++; $display("FAIL rmid_no_stale: got %b required 0", s_valid); end
    start_block(8'h80, 8'd5, 1'b1);
    run_until_done(2, 100, 1'b0);
    compare_block_seq("rmid_restart", 8'h80, 5);
  endtask

  task automatic test_back_to_back();
    s_ready = 1'b1;
    start_block(8'h20, 8'd3, 1'b1);
    for (int i = 0; i < 30 && done_cnt == 0; i++) begin
      @(posedge clk); #1;
    end
    // Now in the first IDLE cycle after done.
    start_block(8'h90, 8'd3, 1'b0);
    run_until_done(0, 50, 1'b0);
    compare_block_seq("b2b", 8'h90, 3);
    checks++; if (first_mem_rel != 1) begin errors++; $display("FAIL b2b_first_mem: got E0+%0d required E0+1", first_mem_rel); end
    checks++; if (done_rel != 5)      begin errors++; $display("FAIL b2b_done_time: got E0+%0d required E0+5", done_rel); end
  endtask

  task automatic test_random();
    logic [7:0] b;
    int n;
    for (int k = 0; k < 5; k++) begin
      b = 8'($urandom);
      n = $urandom_range(1, 24);
      start_block(b, 8'(n), 1'b1);
      run_until_done(2, 400, 1'b1);
      compare_block_seq("random", b, n);
      checks++; if (done_cnt != 1)        begin errors++; $display("FAIL random_done_cnt: got %0d required 1", done_cnt); end
      checks++; if (max_occ > 2)          begin errors++; $display("FAIL random_occupancy: got %0d required <=2", max_occ); end
      checks++; if (hold_viol != 0)       begin errors++; $display("FAIL random_valid_count: got %0d required 0", hold_viol); end
      checks++; if (stab_viol != 0)       begin errors++; $display("FAIL random_stable: got %0d required 0", stab_viol); end
      checks++; if (busy_after_done != 0) begin errors++; $display("FAIL random_busy_fall: got %0d required 0", busy_after_done); end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = {8'($urandom), 32'($urandom)};
    clear_mon();
    test_reset();
    test_basic();
    test_backpressure();
    test_toggle();
    test_wrap();
    test_zero();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_inst_fetch.md
# conv_inst_fetch

Instruction fetch stage directly upstream of `conv_inst_loop`. On a start pulse it reads a contiguous block of 40-bit convolution instructions from a synchronous instruction RAM and presents them, in order, on a valid/ready stream that connects to the loop stage's `m_inst/m_valid/m_ready`. A 2-entry FIFO absorbs the RAM read latency so downstream back-pressure never loses data, and full throughput of one instruction per cycle is sustained.

## Interface
- `IW`, 40, instruction width (fixed by the instruction format).
- `IAW`, 8, instruction RAM address width; also the width of the block length.
- `clk` input 1: the only clock.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: one-cycle request; sampled only in IDLE.
- `base_addr` input IAW: first RAM address; captured on accepted `start`.
- `inst_num` input IAW: number of instructions to fetch; captured on accepted `start`; 0 is legal.
- `busy` output 1: high from the cycle after accepted `start` until `done`, inclusive.
- `done` output 1: one-cycle pulse when the last instruction has been accepted downstream.
- `mem_en` output 1: RAM read enable.
- `mem_addr` output IAW: RAM read address.
- `mem_rdata` input IW: RAM data; valid exactly 1 cycle after `mem_en`.
- `s_inst` output IW: instruction to `conv_inst_loop`.
- `s_valid` output 1: `s_inst` valid.
- `s_ready` input 1: downstream accept.

## Operation
- FSM states: IDLE, FETCH, DRAIN.
- IDLE: `start`=1 captures `base_addr` and `inst_num` and clears the issue and accept counters. If `inst_num`≠0 go to FETCH; if `inst_num`=0 go to DRAIN, which pulses `done` one cycle later with no RAM access.
- FETCH: issue one read per cycle while `issued < inst_num` and credit allows. `mem_addr = base + issued` mod 2^IAW, so the address wraps at the top of RAM. Go to DRAIN in the cycle the last read issues.
- DRAIN: wait until `accepted == inst_num`; assert `done` for that transfer cycle, then return to IDLE.
- Credit rule: issue allowed iff `fifo_cnt + inflight − (s_valid & s_ready) < 2`. `inflight` is 1 if `mem_en` was high last cycle. The combinational path from `s_ready` to `mem_en` is intended.
- Each `mem_rdata` beat (cycle after `mem_en`) is pushed into the FIFO unconditionally; the credit rule guarantees no overflow.
- Stream: `s_valid` = FIFO non-empty; `s_inst` = FIFO head. Once `s_valid` is high, it and `s_inst` hold stable until `s_ready`.
- `start` while busy is ignored.
- `rst` mid-operation: FIFO flushed, counters cleared, state IDLE, any in-flight RAM beat discarded.

## Timing
- Reset values: `busy`=0, `done`=0, `mem_en`=0, `mem_addr`=0, `s_valid`=0, `s_inst`=0.
- `start` sampled at edge E0: `busy` and first `mem_en` in cycle E0+1; data in FIFO and `s_valid` in cycle E0+3.
- With `s_ready` held high, one instruction is transferred per cycle; N instructions finish with `done` in cycle E0+2+N.
- With `s_ready` low, at most 2 reads are issued (FIFO full); issue resumes in the same cycle a pop occurs.
- A push and a pop in the same cycle leave `fifo_cnt` unchanged and keep order.
- `done` and the last transfer coincide; `busy` falls the cycle after `done`.
- A new `start` is accepted in the first cycle back in IDLE.

## Structure
- Shared package `conv_pkg`: `IW`=40, instruction field positions (address [21:8], loop count [28:22]) and the FSM state enum. No field decode here: instructions pass through bit-exact.
- One sub-module: `conv_inst_fifo`, a 2-entry synchronous FIFO with push/pop/count, parameterised on `IW`, and async active-high reset.

## Test plan
- Reset, then `start` with base=0x10, num=4 and `s_ready`=1 → `mem_addr` 0x10..0x13 on consecutive cycles; `s_inst` = RAM[0x10..0x13] back-to-back from E0+3; `done` at E0+6.
- Same start with `s_ready`=0 for 20 cycles → exactly 2 `mem_en` pulses, `s_valid` high with `s_inst` stable; releasing `s_ready` yields all 4 in order with no loss or duplication.
- `s_ready` toggled every cycle, num=6 → 6 transfers in order, `fifo_cnt` never exceeds 2.
- base=0xFE, num=4 → addresses 0xFE, 0xFF, 0x00, 0x01.
- num=0 → no `mem_en`, `s_valid` stays 0, `done` pulses once; a `start` pulse while busy is ignored.
- Assert `rst` mid-block with 1 read in flight → all outputs return to reset values next cycle; a fresh `start` fetches from its new base correctly.
